// File: rtl/pipeline_mem_arbiter.sv
// Shares one external memory bus between the IF and MEM pipeline stages, with
// MEM-priority arbitration, an anti-starvation limit, fetch cancel and bus timeout.
module pipeline_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_MEM_STREAK = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    // instruction-fetch requester
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_cancel,
    output logic                    if_done,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    // load/store requester
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_sel,
    output logic                    mem_done,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    // pipeline stalls
    output logic                    stall_if,
    output logic                    stall_mem,
    // external bus
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_sel,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    bus_err
);

    localparam int SEL_W    = DATA_WIDTH / 8;
    localparam int STREAK_W = (MAX_MEM_STREAK > 0) ? $clog2(MAX_MEM_STREAK + 1) : 1;
    localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic [SEL_W-1:0]      r_bus_sel;
    logic                  r_bus_err;
    logic                  r_if_done;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic                  r_mem_done;
    logic [DATA_WIDTH-1:0] r_mem_rdata;
    logic [STREAK_W-1:0]   r_streak;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  r_cancel;

    logic                  w_if_elig;
    logic                  w_mem_elig;
    logic                  w_streak_ok;
    logic                  w_timeout;
    logic                  w_fetch_dropped;
    logic                  w_grant_if;
    logic                  w_grant_mem;
    logic                  w_end;

    // A requester whose done pulse is high this cycle is not re-granted.
    assign w_if_elig       = if_req & ~r_if_done;
    assign w_mem_elig      = mem_req & ~r_mem_done;
    assign w_streak_ok     = r_streak < STREAK_W'(MAX_MEM_STREAK);
    assign w_timeout       = (TIMEOUT > 0) && r_bus_req && !bus_ack &&
                             (r_tmo_cnt == TMO_W'(TMO_LAST));
    assign w_fetch_dropped = r_cancel | if_cancel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_mem  = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_elig && (!w_if_elig || w_streak_ok)) begin
                    w_grant_mem  = 1'b1;
                    w_state_next = GNT_MEM;
                end else if (w_if_elig && !if_cancel) begin
                    w_grant_if   = 1'b1;
                    w_state_next = GNT_IF;
                end
            end
            GNT_IF, GNT_MEM: begin
                if (bus_ack || w_timeout) begin
                    w_end        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_sel   <= '0;
            r_bus_err   <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= '0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_grant_mem) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= mem_we;
                r_bus_addr  <= mem_addr;
                r_bus_wdata <= mem_wdata;
                r_bus_sel   <= mem_sel;
            end else if (w_grant_if) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_addr  <= if_addr;
                r_bus_wdata <= '0;
                r_bus_sel   <= '1;
            end else if (w_end) begin
                // A timeout completes the owner with zero data.
                r_bus_req <= 1'b0;
                r_bus_err <= w_timeout;
                if (r_state == GNT_MEM) begin
                    r_mem_done <= 1'b1;
                    if (!r_bus_we) r_mem_rdata <= bus_ack ? bus_rdata : '0;
                end else if (!w_fetch_dropped) begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= bus_ack ? bus_rdata : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cancel <= 1'b0;
        end else if (r_state != GNT_IF || w_end) begin
            r_cancel <= 1'b0;
        end else if (if_cancel) begin
            r_cancel <= 1'b1;
        end
    end

    // Consecutive MEM wins over a waiting fetch; any fetch grant or idle IF resets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (!if_req || w_grant_if) begin
            r_streak <= '0;
        end else if (w_grant_mem && w_if_elig && w_streak_ok) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_grant_if || w_grant_mem) begin
            r_tmo_cnt <= '0;
        end else if ((TIMEOUT > 0) && r_bus_req && (r_tmo_cnt != TMO_W'(TMO_LAST))) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_sel   = r_bus_sel;
    assign bus_err   = r_bus_err;
    assign if_done   = r_if_done;
    assign if_rdata  = r_if_rdata;
    assign mem_done  = r_mem_done;
    assign mem_rdata = r_mem_rdata;
    assign stall_if  = if_req & ~r_if_done;
    assign stall_mem = mem_req & ~r_mem_done;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed self-checking bench for pipeline_mem_arbiter (TIMEOUT = 8,
// MAX_MEM_STREAK = 4); the bench plays both pipeline stages and the bus slave.
module tb_pipeline_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_cancel, if_done;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_req, mem_we, mem_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_sel;
    logic          stall_if, stall_mem;
    logic          bus_req, bus_we, bus_ack, bus_err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [3:0]    bus_sel;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_mem_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MAX_MEM_STREAK(4),
        .TIMEOUT       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_cancel(if_cancel),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_sel  (mem_sel),
        .mem_done (mem_done),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_sel  (bus_sel),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each bench cycle starts 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bus_req(input string tag);
        int n = 0;
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        check(tag, bus_req, 1'b1);
    endtask

    // Grant order with both stages requesting: four MEM wins, then IF is forced.
    bit exp_if [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int n;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_cancel = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        tick();
        tick();
        check("rst_bus_req",   bus_req,   1'b0);
        check("rst_bus_err",   bus_err,   1'b0);
        check("rst_if_done",   if_done,   1'b0);
        check("rst_mem_done",  mem_done,  1'b0);
        check("rst_if_rdata",  if_rdata,  32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_bus_addr",  bus_addr,  32'h0);
        rst = 1'b0;
        tick();

        // Single load, ack in the third bus_req cycle.
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h100;
        mem_sel  = 4'hF;
        #1;
        check("ld_stall_mem", stall_mem, 1'b1);
        check("ld_no_req_c0", bus_req,   1'b0);
        tick();
        check("ld_req_c1",  bus_req,  1'b1);
        check("ld_addr",    bus_addr, 32'h100);
        check("ld_we",      bus_we,   1'b0);
        tick();
        check("ld_req_c2",  bus_req,  1'b1);
        tick();
        check("ld_req_c3",  bus_req,  1'b1);
        check("ld_no_done", mem_done, 1'b0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 1'b0;
        check("ld_req_drop",  bus_req,   1'b0);
        check("ld_done",      mem_done,  1'b1);
        check("ld_rdata",     mem_rdata, 32'hDEADBEEF);
        check("ld_stall_off", stall_mem, 1'b0);
        mem_req = 1'b0;
        tick();
        check("ld_done_pulse", mem_done, 1'b0);
        check("ld_no_regrant", bus_req,  1'b0);

        // Store: bus fields follow the MEM request, mem_rdata is left alone.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h204;
        mem_wdata = 32'hAABBCCDD;
        mem_sel   = 4'b0011;
        tick();
        check("st_req",   bus_req,   1'b1);
        check("st_we",    bus_we,    1'b1);
        check("st_addr",  bus_addr,  32'h204);
        check("st_wdata", bus_wdata, 32'hAABBCCDD);
        check("st_sel",   bus_sel,   4'b0011);
        bus_ack   = 1'b1;
        bus_rdata = 32'h55555555;
        tick();
        bus_ack = 1'b0;
        check("st_done",  mem_done,  1'b1);
        check("st_rdata", mem_rdata, 32'hDEADBEEF);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();

        // Conflict and starvation. if_cancel in each mem_done cycle and a MEM
        // bubble in each if_done cycle keep both stages eligible at every grant.
        if_req   = 1'b1;
        if_addr  = 32'h400;
        mem_req  = 1'b1;
        mem_addr = 32'h500;
        mem_sel  = 4'hF;
        for (int g = 0; g < 10; g++) begin
            wait_bus_req("arb_wait");
            check("arb_owner", bus_addr, exp_if[g] ? 32'h400 : 32'h500);
            bus_ack   = 1'b1;
            bus_rdata = 32'h1000 + g;
            tick();
            bus_ack = 1'b0;
            if (exp_if[g]) begin
                check("arb_if_done",  if_done,  1'b1);
                check("arb_if_rdata", if_rdata, 32'h1000 + g);
                mem_req = 1'b0;
            end else begin
                check("arb_mem_done", mem_done, 1'b1);
                if_cancel = 1'b1;
            end
            if (g == 9) if_req = 1'b0;
            tick();
            if_cancel = 1'b0;
            if (g != 9) mem_req = 1'b1;
        end
        check("arb_mem_rdata", mem_rdata, 32'h1008);
        tick();

        // Fetch cancelled in its second bus cycle.
        if_req  = 1'b1;
        if_addr = 32'h800;
        #1;
        check("fc_stall_if", stall_if, 1'b1);
        tick();
        check("fc_req",  bus_req, 1'b1);
        check("fc_addr", bus_addr, 32'h800);
        check("fc_sel",  bus_sel, 4'hF);
        tick();
        if_cancel = 1'b1;
        tick();
        if_cancel = 1'b0;
        if_req    = 1'b0;
        check("fc_req_held", bus_req, 1'b1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h13;
        tick();
        bus_ack = 1'b0;
        check("fc_no_done", if_done,  1'b0);
        check("fc_rdata",   if_rdata, 32'h1009);
        check("fc_idle",    bus_req,  1'b0);
        tick();
        check("fc_no_done2", if_done, 1'b0);

        // Timeout: fetch never acknowledged.
        if_req  = 1'b1;
        if_addr = 32'hC00;
        tick();
        n = 0;
        while (bus_req && n < 20) begin
            n++;
            tick();
        end
        check("to_req_cycles", n,        8);
        check("to_err",        bus_err,  1'b1);
        check("to_if_done",    if_done,  1'b1);
        check("to_if_rdata",   if_rdata, 32'h0);
        if_req = 1'b0;
        tick();
        check("to_err_pulse",  bus_err,  1'b0);
        check("to_done_pulse", if_done,  1'b0);

        // Stray ack while idle.
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_mem", mem_done,  1'b0);
        check("idle_ack_if",  if_done,   1'b0);
        check("idle_ack_rd",  mem_rdata, 32'h1008);

        // Reset during a MEM transfer drops bus_req without a clock edge.
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h300;
        tick();
        check("rm_req", bus_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rm_async_drop", bus_req, 1'b0);
        tick();
        check("rm_in_reset", bus_req, 1'b0);
        rst = 1'b0;
        #1;
        check("rm_released", bus_req, 1'b0);
        tick();
        check("rm_no_done", mem_done, 1'b0);
        check("rm_regrant", bus_req,  1'b1);
        check("rm_addr",    bus_addr, 32'h300);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BADF00D;
        tick();
        bus_ack = 1'b0;
        mem_req = 1'b0;
        check("rm_done",  mem_done,  1'b1);
        check("rm_rdata", mem_rdata, 32'h0BADF00D);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

endmodule

// File: doc/pipeline_mem_arbiter.md
Name: pipeline_mem_arbiter

Overview:
- Shares the core's single external memory bus between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage).
- Sequences one bus transaction at a time using a req/ack handshake, and returns a one-cycle done pulse plus read data to the owning stage.
- Drives per-stage stall requests to the pipeline registers.
- Supports fetch cancellation on branch redirect, MEM-priority arbitration with an anti-starvation limit, and a bus-timeout abort.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the bus.
- DATA_WIDTH, 32, data width; byte selects are DATA_WIDTH/8 bits wide.
- MAX_MEM_STREAK, 4, consecutive MEM grants allowed while if_req is pending before IF must win.
- TIMEOUT, 64, number of bus_req cycles without bus_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request level; held with if_addr stable until if_done or if_cancel.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_cancel  in  1  one-cycle pulse: discard the in-flight or pending fetch (branch redirect).
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_WIDTH  fetched word; holds its value between completions.
- mem_req  in  1  load/store request level; held stable until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_WIDTH  load/store address.
- mem_wdata  in  DATA_WIDTH  store data.
- mem_sel  in  DATA_WIDTH/8  byte enables.
- mem_done  out  1  one-cycle pulse: load/store complete.
- mem_rdata  out  DATA_WIDTH  load data; updated on loads only.
- stall_if  out  1  combinational: if_req & ~if_done.
- stall_mem  out  1  combinational: mem_req & ~mem_done.
- bus_req  out  1  registered bus request.
- bus_we  out  1  registered write enable.
- bus_addr  out  ADDR_WIDTH  registered address.
- bus_wdata  out  DATA_WIDTH  registered write data.
- bus_sel  out  DATA_WIDTH/8  registered byte enables; all ones for fetches.
- bus_ack  in  1  one-cycle acknowledge; bus_rdata valid in the same cycle.
- bus_rdata  in  DATA_WIDTH  read data from the bus.
- bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: state IDLE. All outputs 0, streak counter 0, timeout counter 0, cancel flag 0. Reset is asynchronous, so bus_req drops immediately even mid-transaction.
- FSM states: IDLE, GNT_IF, GNT_MEM.
- Eligibility in IDLE: a requester is eligible if its req is high and its done is NOT high in the current cycle. This blocks a re-grant of a request that is just completing.
- IDLE -> GNT_MEM when MEM is eligible and (IF is not eligible, or streak < MAX_MEM_STREAK).
- IDLE -> GNT_IF when IF is eligible and MEM is not granted. A fetch is not granted in a cycle where if_cancel is high.
- On the grant edge, bus_req=1 and bus_addr/we/wdata/sel are loaded from the winner.
- Streak counter: incremented on a MEM grant while IF is eligible (saturates at MAX_MEM_STREAK); cleared on any IF grant and whenever if_req is low.
- Busy states: bus_req stays high until an edge where bus_ack=1. At that edge:
  - bus_req clears and the state returns to IDLE.
  - In GNT_MEM: mem_done pulses the next cycle; mem_rdata is latched from bus_rdata only if bus_we=0.
  - In GNT_IF: if_done pulses and if_rdata is latched, unless the cancel flag is set or if_cancel is high in the ack cycle.
- Minimum latency: request seen in cycle 0 -> bus_req in cycle 1 -> ack in cycle 1 -> done in cycle 2 -> next grant's bus_req in cycle 3.
- if_cancel:
  - In GNT_IF: sets the cancel flag; the bus transaction still completes, and no if_done is produced.
  - In IDLE or GNT_MEM: no effect beyond blocking a same-cycle fetch grant.
  - The cancel flag clears on return to IDLE.
- Timeout (TIMEOUT>0): the counter counts cycles with bus_req=1 and clears on grant. If it reaches TIMEOUT-1 with no ack:
  - bus_req clears, bus_err pulses for one cycle, and the state returns to IDLE.
  - The owner receives its done pulse with rdata=0 (a cancelled fetch receives no done).
- A bus_ack that arrives while in IDLE is ignored.
- Simultaneous if_req and mem_req with streak < MAX_MEM_STREAK: MEM wins, because it belongs to the older instruction.

Test Plan:
- Single load: mem_req=1, mem_we=0, addr 0x100; bus_ack in the 3rd bus_req cycle with rdata 0xDEADBEEF -> bus_req high for 3 cycles, mem_done one cycle later, mem_rdata=0xDEADBEEF, stall_mem low after done.
- Conflict and starvation: if_req and mem_req held continuously, ack after 1 cycle each -> grant order MEM×4, IF, MEM×4, IF; streak returns to 0 after each IF grant.
- Fetch cancel: IF granted, if_cancel pulsed in the 2nd bus cycle, ack with 0x13 -> no if_done, if_rdata unchanged, IDLE one cycle after ack.
- Store: mem_we=1, sel=4'b0011, wdata 0xAABBCCDD -> bus fields match, mem_done pulses, mem_rdata unchanged.
- Timeout: TIMEOUT=8, fetch with no ack -> bus_req drops after 8 cycles, bus_err pulses 1 cycle, if_done pulses with if_rdata=0.
- Reset mid-transfer: rst asserted during GNT_MEM -> bus_req low with no clock edge; after release, state is IDLE and no done pulse is produced.
